decode_ctl: RTL and testbench
=============================

Name: decode_ctl

Overview:
- Decode-stage front end and controller of the RISC-V core.
- Accepts fetched instruction/PC pairs over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Classifies the instruction format, extracts register fields, and sequences the existing igen immediate generator on the buffered instruction.
- Presents a decoded bundle to the execute stage with its own valid/ready handshake, honours pipeline flushes, and counts decoded instructions.

Parameters:
DWIDTH, 32, instruction and immediate width
AWIDTH, 32, PC width
CWIDTH, 32, decoded-instruction counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid_i  in  1  fetch presents pc_i/insn_i
in_ready_o  out  1  decode can accept; registered
pc_i  in  AWIDTH  PC of fetched instruction
insn_i  in  DWIDTH  fetched instruction word
flush_i  in  1  discard all buffered and incoming instructions this cycle
out_valid_o  out  1  decoded bundle valid
out_ready_i  in  1  execute accepts bundle
pc_o  out  AWIDTH  PC of head entry
insn_o  out  DWIDTH  raw head instruction
opcode_o  out  7  insn[6:0]
rd_o / rs1_o / rs2_o  out  5 each  insn[11:7] / [19:15] / [24:20]
funct3_o  out  3  insn[14:12]
funct7_o  out  7  insn[31:25]
fmt_o  out  3  format code (fmt_e)
imm_o  out  DWIDTH  sign-extended immediate from igen
illegal_o  out  1  head instruction unrecognised
dec_count_o  out  CWIDTH  count of completed output transfers

Behaviour:
- Storage: entries MAIN (head, drives outputs) and SKID, each {valid, pc, insn}.
- out_valid_o = MAIN.valid. in_ready_o = !SKID.valid, registered.
- Accept = in_valid_i & in_ready_o. Drain = out_valid_o & out_ready_i.
- Per cycle, when not flushing:
  - MAIN empty or draining, SKID empty: accepted input loads MAIN. No accept while draining: MAIN.valid clears.
  - MAIN full and not draining, accept: input loads SKID; in_ready_o falls next cycle.
  - Drain with SKID valid: SKID moves to MAIN and SKID clears. An accept is impossible that cycle (in_ready_o=0).
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.
- Latency: input accepted at edge N appears on outputs after edge N (combinational from MAIN) when the buffer was empty. Max occupancy 2.
- Full-throughput: with out_ready_i held 1, one instruction per cycle and SKID never fills.
- Flush:
  - flush_i clears MAIN.valid and SKID.valid at the edge.
  - Flush has priority over a same-cycle accept: the input is dropped.
  - A same-cycle drain still completes downstream and is counted.
  - in_ready_o=1 the cycle after flush.
- Decode is combinational from MAIN:
  - 0110011 -> R, imm=0
  - 0010011 / 0000011 / 1100111 / 1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111 / 0010111 -> U
  - 1101111 -> J
- Illegal: any other opcode, or insn[1:0]!=2'b11. Then fmt=ILLEGAL, illegal_o=1, imm_o=0, and the bundle still flows (execute raises the trap).
- Immediate: igen sub-instance is driven with MAIN opcode/insn. Its output is muxed to 0 for R and ILLEGAL.
- When MAIN invalid: data outputs hold last MAIN contents (don't-care); illegal_o forced 0.
- dec_count_o: +1 on each drain; wraps modulo 2^CWIDTH.
- Reset: both entries invalid, in_ready_o=1, out_valid_o=0, dec_count_o=0, pc/insn registers 0 (so fmt_o=ILLEGAL code but illegal_o=0).
  - Reset mid-operation discards buffered entries identically to flush and also zeroes the counter.
  - rst has priority over flush_i and handshakes.
- in_ready_o never depends combinationally on out_ready_i.

Decomposition:
- Shared package decode_pkg:
  - fmt_e enum: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
  - Opcode localparams: OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYS, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
  - The package is also imported by igen.
- Sub-module: existing igen, instantiated once. The skid buffer stays inline.

Test Plan:
- Reset, then in pc_i=0x01000000, insn_i=0xFFB10093, out_ready_i=1 -> next cycle out_valid_o=1, fmt=I, rd=1, rs1=2, imm_o=0xFFFFFFFB, dec_count_o=1 after drain.
- out_ready_i=0, push 0x00512423, 0xFE208EE3, 0x123450B7 back-to-back -> in_ready_o=0 after second accept, third held by fetch; raise out_ready_i -> outputs in order:
  - S imm 0x00000008
  - B imm 0xFFFFFFFC
  - U imm 0x12345000
- Two entries buffered, assert flush_i with in_valid_i=1 (0x001000EF) -> next cycle out_valid_o=0, in_ready_o=1, 0x001000EF never emitted.
- insn 0x0000007F (undefined opcode) and 0x00000090 (insn[1:0]=00) -> illegal_o=1, fmt=ILLEGAL, imm_o=0; bundle drains normally.
- Streaming 16 instructions with out_ready_i=1 -> 16 consecutive valid output cycles, in_ready_o constantly 1, dec_count_o=16; assert rst mid-stream -> count 0, out_valid_o=0 next cycle.
- Preload dec_count_o near wrap (CWIDTH=4, 15 drains, then 1 more) -> dec_count_o wraps to 0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared formats, opcodes and opcode classifier for the decode stage.
package decode_pkg;
   typedef enum logic [2:0] {R = 3'd0, I = 3'd1, S = 3'd2, B = 3'd3, U = 3'd4, J = 3'd5, ILLEGAL = 3'd7} fmt_e;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYS    = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   // Every legal opcode ends in 2'b11, so a bad low pair falls through to ILLEGAL.
   function automatic fmt_e fmt_of(input logic [6:0] op);
      case (op)
         OP_R:                             return R;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYS: return I;
         OP_STORE:                         return S;
         OP_BRANCH:                        return B;
         OP_LUI, OP_AUIPC:                 return U;
         OP_JAL:                           return J;
         default:                          return ILLEGAL;
      endcase
   endfunction
endpackage

// File: rtl/decode_ctl_if.sv
// decode_ctl_if: fetch-side and execute-side handshake bundle of the decode stage.
interface decode_ctl_if import decode_pkg::*; #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32,
   parameter int CWIDTH = 32
);
   logic              in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i, illegal_o;
   logic [AWIDTH-1:0] pc_i, pc_o;
   logic [DWIDTH-1:0] insn_i, insn_o, imm_o;
   logic [6:0]        opcode_o, funct7_o;
   logic [4:0]        rd_o, rs1_o, rs2_o;
   logic [2:0]        funct3_o;
   fmt_e              fmt_o;
   logic [CWIDTH-1:0] dec_count_o;
   modport slave (
      input  in_valid_i, pc_i, insn_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
             funct3_o, funct7_o, fmt_o, imm_o, illegal_o, dec_count_o
   );
   modport master (
      output in_valid_i, pc_i, insn_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
             funct3_o, funct7_o, fmt_o, imm_o, illegal_o, dec_count_o
   );
endinterface

// File: rtl/igen.sv
// igen: sign-extended immediate generator for the base integer formats.
module igen import decode_pkg::*; #(
   parameter int DWIDTH = 32
) (
   input  logic [6:0]        opcode_i,
   input  logic [DWIDTH-1:0] insn_i,
   output logic [DWIDTH-1:0] imm_o
);
   fmt_e fmt;
   logic unused_opcode_bits;
   assign unused_opcode_bits = ^insn_i[6:0];
   assign fmt = fmt_of(opcode_i);
   assign imm_o = fmt == I ? DWIDTH'($signed(insn_i[31:20]))
                : fmt == S ? DWIDTH'($signed({insn_i[31:25], insn_i[11:7]}))
                : fmt == B ? DWIDTH'($signed({insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0}))
                : fmt == U ? DWIDTH'($signed({insn_i[31:12], 12'b0}))
                : fmt == J ? DWIDTH'($signed({insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0}))
                : '0;
endmodule

// File: rtl/decode_ctl.sv
// decode_ctl: decode-stage skid buffer, field/format decode and drain counter.
module decode_ctl import decode_pkg::*; #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32,
   parameter int CWIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   decode_ctl_if.slave bus
);
   logic              main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, acc, drn, ld_main, ld_skid;
   logic [AWIDTH-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
   logic [DWIDTH-1:0] main_insn_q, main_insn_d, skid_insn_q, skid_insn_d, igen_imm;
   logic [CWIDTH-1:0] cnt_q;
   fmt_e              fmt;
   always_comb begin
      acc         = bus.in_valid_i & rdy_q;
      drn         = main_v_q & bus.out_ready_i;
      ld_main     = acc & (!main_v_q | drn);
      ld_skid     = acc & main_v_q & !drn;
      main_v_d    = !bus.flush_i & (skid_v_q | acc | (main_v_q & !drn));
      skid_v_d    = !bus.flush_i & (skid_v_q ? !drn : ld_skid);
      main_pc_d   = skid_v_q & drn ? skid_pc_q : ld_main ? bus.pc_i : main_pc_q;
      main_insn_d = skid_v_q & drn ? skid_insn_q : ld_main ? bus.insn_i : main_insn_q;
      skid_pc_d   = ld_skid ? bus.pc_i : skid_pc_q;
      skid_insn_d = ld_skid ? bus.insn_i : skid_insn_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v_q    <= 1'b0;
         skid_v_q    <= 1'b0;
         rdy_q       <= 1'b1;
         main_pc_q   <= '0;
         main_insn_q <= '0;
         skid_pc_q   <= '0;
         skid_insn_q <= '0;
         cnt_q       <= '0;
      end else begin
         main_v_q    <= main_v_d;
         skid_v_q    <= skid_v_d;
         rdy_q       <= !skid_v_d;
         main_pc_q   <= main_pc_d;
         main_insn_q <= main_insn_d;
         skid_pc_q   <= skid_pc_d;
         skid_insn_q <= skid_insn_d;
         cnt_q       <= cnt_q + CWIDTH'(drn);
      end
   end
   igen #(.DWIDTH(DWIDTH)) u_igen (
      .opcode_i (main_insn_q[6:0]),
      .insn_i   (main_insn_q),
      .imm_o    (igen_imm)
   );
   assign fmt             = fmt_of(main_insn_q[6:0]);
   assign bus.in_ready_o  = rdy_q;
   assign bus.out_valid_o = main_v_q;
   assign bus.pc_o        = main_pc_q;
   assign bus.insn_o      = main_insn_q;
   assign bus.opcode_o    = main_insn_q[6:0];
   assign bus.rd_o        = main_insn_q[11:7];
   assign bus.funct3_o    = main_insn_q[14:12];
   assign bus.rs1_o       = main_insn_q[19:15];
   assign bus.rs2_o       = main_insn_q[24:20];
   assign bus.funct7_o    = main_insn_q[31:25];
   assign bus.fmt_o       = fmt;
   assign bus.imm_o       = (fmt == R || fmt == ILLEGAL) ? '0 : igen_imm;
   assign bus.illegal_o   = main_v_q & (fmt == ILLEGAL);
   assign bus.dec_count_o = cnt_q;
endmodule

// File: tb/tb_decode_ctl.sv
// tb_decode_ctl: directed vectors for the decode stage, with a 4-bit counter copy for wrap.
module tb_decode_ctl;
   import decode_pkg::*;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   decode_ctl_if #(.DWIDTH(32), .AWIDTH(32), .CWIDTH(32)) bus ();
   decode_ctl_if #(.DWIDTH(32), .AWIDTH(32), .CWIDTH(4))  bus4 ();
   assign bus4.in_valid_i  = bus.in_valid_i;
   assign bus4.pc_i        = bus.pc_i;
   assign bus4.insn_i      = bus.insn_i;
   assign bus4.flush_i     = bus.flush_i;
   assign bus4.out_ready_i = bus.out_ready_i;
   decode_ctl #(.DWIDTH(32), .AWIDTH(32), .CWIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   decode_ctl #(.DWIDTH(32), .AWIDTH(32), .CWIDTH(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));
   int errs = 0;
   int checks = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [31:0] pc, input logic [31:0] insn);
      bus.in_valid_i = 1'b1;
      bus.pc_i       = pc;
      bus.insn_i     = insn;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid_i = 1'b0;
      bus.flush_i    = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask
   initial begin
      bus.pc_i = '0;
      bus.insn_i = '0;
      bus.out_ready_i = 1'b0;
      do_reset();
      chk("rst_in_ready", 32'(bus.in_ready_o), 1);
      chk("rst_out_valid", 32'(bus.out_valid_o), 0);
      chk("rst_count", bus.dec_count_o, 0);
      chk("rst_fmt", 32'(bus.fmt_o), 7);
      chk("rst_illegal", 32'(bus.illegal_o), 0);
      // single I-type with execute ready
      bus.out_ready_i = 1'b1;
      push(32'h0100_0000, 32'hFFB1_0093);
      step();
      bus.in_valid_i = 1'b0;
      chk("t1_valid", 32'(bus.out_valid_o), 1);
      chk("t1_fmt", 32'(bus.fmt_o), 1);
      chk("t1_rd", 32'(bus.rd_o), 1);
      chk("t1_rs1", 32'(bus.rs1_o), 2);
      chk("t1_imm", bus.imm_o, 32'hFFFF_FFFB);
      chk("t1_pc", bus.pc_o, 32'h0100_0000);
      step();
      chk("t1_count", bus.dec_count_o, 1);
      chk("t1_empty", 32'(bus.out_valid_o), 0);
      // back-pressure fills the skid, then drain in order
      bus.out_ready_i = 1'b0;
      push(32'h4, 32'h0051_2423);
      step();
      chk("t2_rdy1", 32'(bus.in_ready_o), 1);
      push(32'h8, 32'hFE20_8EE3);
      step();
      chk("t2_rdy2", 32'(bus.in_ready_o), 0);
      push(32'hC, 32'h1234_50B7);
      step();
      chk("t2_rdy3", 32'(bus.in_ready_o), 0);
      chk("t2_s_fmt", 32'(bus.fmt_o), 2);
      chk("t2_s_imm", bus.imm_o, 32'h0000_0008);
      chk("t2_s_pc", bus.pc_o, 32'h4);
      bus.out_ready_i = 1'b1;
      step();
      chk("t2_b_fmt", 32'(bus.fmt_o), 3);
      chk("t2_b_imm", bus.imm_o, 32'hFFFF_FFFC);
      chk("t2_b_pc", bus.pc_o, 32'h8);
      chk("t2_rdy4", 32'(bus.in_ready_o), 1);
      step();
      bus.in_valid_i = 1'b0;
      chk("t2_u_fmt", 32'(bus.fmt_o), 4);
      chk("t2_u_imm", bus.imm_o, 32'h1234_5000);
      chk("t2_u_pc", bus.pc_o, 32'hC);
      step();
      chk("t2_count", bus.dec_count_o, 4);
      chk("t2_empty", 32'(bus.out_valid_o), 0);
      // flush with both entries full and fetch offering JAL
      bus.out_ready_i = 1'b0;
      push(32'h20, 32'h0000_0013);
      step();
      push(32'h24, 32'h0010_0093);
      step();
      chk("t3_full", 32'(bus.in_ready_o), 0);
      push(32'h28, 32'h0010_00EF);
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      bus.in_valid_i = 1'b0;
      chk("t3_valid", 32'(bus.out_valid_o), 0);
      chk("t3_rdy", 32'(bus.in_ready_o), 1);
      bus.out_ready_i = 1'b1;
      step();
      chk("t3_none", 32'(bus.out_valid_o), 0);
      chk("t3_count", bus.dec_count_o, 4);
      // flush wins over a same-cycle accept
      bus.out_ready_i = 1'b0;
      push(32'h2C, 32'h0000_0013);
      step();
      push(32'h30, 32'h0010_00EF);
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      bus.in_valid_i = 1'b0;
      chk("t3_drop", 32'(bus.out_valid_o), 0);
      // a drain coinciding with flush still counts
      push(32'h34, 32'h0000_0013);
      step();
      bus.in_valid_i = 1'b0;
      bus.out_ready_i = 1'b1;
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      chk("t3_flush_drain", bus.dec_count_o, 5);
      chk("t3_flush_empty", 32'(bus.out_valid_o), 0);
      // illegal encodings still flow
      bus.out_ready_i = 1'b0;
      push(32'h40, 32'h0000_007F);
      step();
      chk("t4_ill1", 32'(bus.illegal_o), 1);
      chk("t4_fmt1", 32'(bus.fmt_o), 7);
      chk("t4_imm1", bus.imm_o, 0);
      bus.out_ready_i = 1'b1;
      push(32'h44, 32'h0000_0090);
      step();
      bus.in_valid_i = 1'b0;
      chk("t4_ill2", 32'(bus.illegal_o), 1);
      chk("t4_fmt2", 32'(bus.fmt_o), 7);
      chk("t4_imm2", bus.imm_o, 0);
      chk("t4_insn2", bus.insn_o, 32'h0000_0090);
      step();
      chk("t4_count", bus.dec_count_o, 7);
      chk("t4_noill", 32'(bus.illegal_o), 0);
      // streaming at full rate
      do_reset();
      bus.out_ready_i = 1'b1;
      for (int k = 0; k < 16; k++) begin
         push(32'h100 + 32'(4 * k), 32'h0000_0013);
         step();
         chk("t5_valid", 32'(bus.out_valid_o), 1);
         chk("t5_rdy", 32'(bus.in_ready_o), 1);
         chk("t5_pc", bus.pc_o, 32'h100 + 32'(4 * k));
      end
      bus.in_valid_i = 1'b0;
      step();
      chk("t5_count", bus.dec_count_o, 16);
      chk("t5_count4", 32'(bus4.dec_count_o), 0);
      for (int k = 0; k < 3; k++) begin
         push(32'h200 + 32'(4 * k), 32'h0000_0013);
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.in_valid_i = 1'b0;
      chk("t5_rst_count", bus.dec_count_o, 0);
      chk("t5_rst_valid", 32'(bus.out_valid_o), 0);
      chk("t5_rst_rdy", 32'(bus.in_ready_o), 1);
      // 4-bit counter wrap
      do_reset();
      bus.out_ready_i = 1'b1;
      for (int k = 0; k < 15; k++) begin
         push(32'h300 + 32'(4 * k), 32'h0000_0013);
         step();
      end
      bus.in_valid_i = 1'b0;
      step();
      chk("t6_cnt15", 32'(bus4.dec_count_o), 15);
      push(32'h400, 32'h0000_0013);
      step();
      bus.in_valid_i = 1'b0;
      step();
      chk("t6_wrap", 32'(bus4.dec_count_o), 0);
      chk("t6_wide", bus.dec_count_o, 16);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
